// File: rtl/tt_sweeper_pkg.sv
// ============================================================================
// tt_sweeper_pkg : shared types and constants for the truth-table sweeper
// Revision       : 1.0
// ============================================================================
`default_nettype none

package tt_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // sillyfunction: y = ~b&~c | a&~b, indexed by {a,b,c}
  localparam logic [7:0] SILLY_EXPECTED = 8'h31;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_sweeper_settle_timer.sv
// ============================================================================
// settle_timer : counts enabled cycles; expire marks the SETTLE-th one
// Revision     : 1.0
// ============================================================================
`default_nettype none

module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int             CW   = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  LAST = CW'(SETTLE - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = expire ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tt_sweeper.sv
// ============================================================================
// tt_sweeper : sweeps all inputs of a combinational DUT and scores its output
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tt_sweeper
  import tt_sweeper_pkg::*;
#(
  parameter int                     N_IN     = 3,
  parameter int                     SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]   EXPECTED = (2**N_IN)'(SILLY_EXPECTED),
  localparam int                    N_VEC    = n_vec(N_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_VEC-1:0]  results,
  output logic [N_IN:0]     err_count,
  output logic              err_valid,
  output logic [N_IN-1:0]   first_err_idx
);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     stim_q, stim_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_VEC-1:0]    results_q, results_d;
  logic [N_IN:0]       err_count_q, err_count_d;
  logic                err_valid_q, err_valid_d;
  logic [N_IN-1:0]     first_err_q, first_err_d;
  logic                timer_clear, timer_en, timer_expire;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // stim doubles as the sweep index; it is forced to 0 outside DRIVE
  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    results_d   = results_q;
    err_count_d = err_count_q;
    err_valid_d = err_valid_q;
    first_err_d = first_err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DRIVE;
          stim_d      = '0;
          busy_d      = 1'b1;
          timer_clear = 1'b1;
          results_d   = '0;
          err_count_d = '0;
          err_valid_d = 1'b0;
          first_err_d = '0;
          pass_d      = 1'b0;
        end
      end

      DRIVE: begin
        timer_en = 1'b1;
        if (timer_expire) begin
          results_d[stim_q] = resp;
          if (resp != EXPECTED[stim_q]) begin
            err_count_d = err_count_q + (N_IN+1)'(1);
            err_valid_d = 1'b1;
            if (!err_valid_q) begin
              first_err_d = stim_q;
            end
          end
          if (stim_q == '1) begin
            state_d = DONE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end else begin
            stim_d = stim_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      results_q   <= '0;
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      results_q   <= results_d;
      err_count_q <= err_count_d;
      err_valid_q <= err_valid_d;
      first_err_q <= first_err_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign results       = results_q;
  assign err_count     = err_count_q;
  assign err_valid     = err_valid_q;
  assign first_err_idx = first_err_q;

endmodule

`default_nettype wire

// File: doc/tt_sweeper.md
Name: tt_sweeper

Overview:
- Synthesizable stimulus/response engine: the driving end of a combinational DUT interface.
- Sweeps every input combination of an N_IN-input, single-output combinational block (e.g. sillyfunction) and holds each vector for SETTLE cycles.
- Samples the DUT output, builds the observed truth table and compares it against an expected truth table.
- Sits beside the DUT in on-board self-test wrappers. Replaces hand-written display testbenches with a hardware pass/fail result.

Parameters:
- N_IN, 3, number of DUT inputs; stim bit N_IN-1 maps to DUT input a (MSB), bit 0 to c.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..255.
- EXPECTED, 8'h31, 2**N_IN-bit expected truth table; bit i = expected resp for stim == i. Default is sillyfunction: y = ~b&~c | a&~b.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (asserted when 0)
- start  in  1  level-sampled request to begin a sweep; honoured only in IDLE
- stim  out  N_IN  vector driven to DUT inputs
- resp  in  1  DUT output; synchronous to clk
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  1 when the last completed sweep had zero mismatches
- results  out  2**N_IN  observed truth table; bit i = resp sampled for stim == i
- err_count  out  N_IN+1  mismatch count for the current/last sweep; max 2**N_IN, no saturation needed
- err_valid  out  1  at least one mismatch seen in the current/last sweep
- first_err_idx  out  N_IN  lowest stim index that mismatched; meaningful only when err_valid = 1

Behaviour:
- Reset (reset = 0, asynchronous, takes effect immediately):
  - state = IDLE.
  - stim, busy, done, pass, results, err_count, err_valid, first_err_idx all 0.
  - Settle counter and index cleared.
- FSM states: IDLE, DRIVE, DONE.
- IDLE -> DRIVE:
  - Occurs at edge E0 where start = 1.
  - At E0: stim <= 0, busy <= 1, settle counter <= 0.
  - At E0: results, err_count, err_valid, first_err_idx <= 0 and pass <= 0.
- DRIVE:
  - stim is held; the settle counter increments each edge.
  - On the edge ending the SETTLE-th cycle of a vector, resp is sampled: results[idx] <= resp.
  - Mismatch is resp != EXPECTED[idx]. On a mismatch: err_count += 1, err_valid <= 1.
  - If err_valid was 0 before this sample, first_err_idx <= idx.
  - Samples therefore land at edges E0 + k*SETTLE, for k = 1..2**N_IN.
  - If idx < 2**N_IN-1: stim <= idx+1, counter <= 0, stay in DRIVE.
  - If idx = 2**N_IN-1 (last vector): go to DONE, stim <= 0, busy <= 0, done <= 1.
  - pass <= (final err_count == 0), computed including the final sample.
- DONE:
  - Lasts exactly one cycle, then IDLE with done <= 0.
  - start is ignored in DONE.
- start while busy or in DONE is ignored. No queuing, no restart.
- results, err_*, pass hold their values in IDLE until the next accepted start.
- stim is 0 in IDLE and DONE.
- Reset asserted mid-sweep aborts immediately to the reset values; done is not pulsed.
- The sweep index wraps only via the DONE transition. The index width is N_IN; the terminal compare is on the all-ones value.

Decomposition:
- Package tt_sweeper_pkg holds:
  - state typedef (enum IDLE, DRIVE, DONE);
  - constant SILLY_EXPECTED = 8'h31;
  - localparam helper N_VEC = 2**N_IN, as a function of N_IN.
- Sub-module settle_timer: counter of width clog2(SETTLE+1).
  - Inputs: clk, reset, clear, en.
  - Output: expire, high on the SETTLE-th enabled cycle.
- The FSM and scoreboard stay in tt_sweeper.

Test Plan:
- sillyfunction DUT, defaults, start pulsed 1 cycle at E0 -> stim steps 0..7, one per cycle; busy high after E0 through E8; done pulse after E8; results = 8'h31, err_count = 0, err_valid = 0, pass = 1.
- resp tied 0, EXPECTED = 8'h31 -> results = 8'h00, err_count = 3, err_valid = 1, first_err_idx = 0, pass = 0.
- DUT model equal to sillyfunction except output inverted at stim = 5 -> results = 8'h11, err_count = 1, first_err_idx = 5, pass = 0.
- SETTLE = 3, correct DUT -> each stim value held 3 cycles; busy for 24 cycles; done after E24; pass = 1.
- start reasserted while stim = 3 and held high through DONE -> no restart during sweep or in DONE; a new sweep starts on the first IDLE edge; the first sweep still has results = 8'h31.
- reset driven low while stim = 4 -> stim, busy, results, err_count go to 0 without a clock edge; no done pulse; after release, start runs a full clean 8-vector sweep with pass = 1.
